// File: rtl/axi_sram_slave.sv
// AXI3-style slave bridging one transaction at a time onto a single-port SRAM.
// Reads take a fetch cycle per beat; write termination follows WLAST.
module axi_sram_slave (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  ARID_S,
   input  logic [31:0] ARADDR_S,
   input  logic [3:0]  ARLEN_S,
   input  logic [2:0]  ARSIZE_S,
   input  logic [1:0]  ARBURST_S,
   input  logic        ARVALID_S,
   output logic        ARREADY_S,
   output logic [7:0]  RID_S,
   output logic [31:0] RDATA_S,
   output logic [1:0]  RRESP_S,
   output logic        RLAST_S,
   output logic        RVALID_S,
   input  logic        RREADY_S,
   input  logic [7:0]  AWID_S,
   input  logic [31:0] AWADDR_S,
   input  logic [3:0]  AWLEN_S,
   input  logic [2:0]  AWSIZE_S,
   input  logic [1:0]  AWBURST_S,
   input  logic        AWVALID_S,
   output logic        AWREADY_S,
   input  logic [31:0] WDATA_S,
   input  logic [3:0]  WSTRB_S,
   input  logic        WLAST_S,
   input  logic        WVALID_S,
   output logic        WREADY_S,
   output logic [7:0]  BID_S,
   output logic [1:0]  BRESP_S,
   output logic        BVALID_S,
   input  logic        BREADY_S,
   output logic        sram_cs,
   output logic [3:0]  sram_we,
   output logic [13:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata
);

   typedef enum logic [2:0] {
      IDLE, R_FETCH, R_SEND, W_DATA, W_RESP
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  id_q, id_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  len_q, len_d;
   logic [2:0]  size_q, size_d;
   logic [3:0]  beat_q, beat_d;
   logic        err_q, err_d;

   logic [31:0] addr_inc;
   logic [3:0]  beat_inc;
   logic        at_len;
   logic        unused_burst;

   // Burst type is accepted but every burst is handled as INCR.
   assign unused_burst = ^{ARBURST_S, AWBURST_S};
   assign addr_inc = addr_q + (32'd1 << size_q);
   assign beat_inc = (beat_q == 4'hF) ? beat_q : beat_q + 4'd1;
   assign at_len   = (beat_q == len_q);

   // State and transaction context registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         id_q    <= '0;
         addr_q  <= '0;
         len_q   <= '0;
         size_q  <= '0;
         beat_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         size_q  <= size_d;
         beat_q  <= beat_d;
         err_q   <= err_d;
      end
   end

   // Next-state, channel outputs and SRAM strobes.
   always_comb begin
      state_d    = state_q;
      id_d       = id_q;
      addr_d     = addr_q;
      len_d      = len_q;
      size_d     = size_q;
      beat_d     = beat_q;
      err_d      = err_q;
      ARREADY_S  = 1'b0;
      AWREADY_S  = 1'b0;
      WREADY_S   = 1'b0;
      RID_S      = '0;
      RDATA_S    = '0;
      RRESP_S    = 2'b00;
      RLAST_S    = 1'b0;
      RVALID_S   = 1'b0;
      BID_S      = '0;
      BRESP_S    = 2'b00;
      BVALID_S   = 1'b0;
      sram_cs    = 1'b0;
      sram_we    = '0;
      sram_addr  = '0;
      sram_wdata = '0;
      case (state_q)
         IDLE: begin
            ARREADY_S = 1'b1;
            AWREADY_S = !ARVALID_S;
            if (ARVALID_S) begin
               id_d    = ARID_S;
               addr_d  = ARADDR_S;
               len_d   = ARLEN_S;
               size_d  = ARSIZE_S;
               beat_d  = '0;
               state_d = R_FETCH;
            end else if (AWVALID_S) begin
               id_d    = AWID_S;
               addr_d  = AWADDR_S;
               len_d   = AWLEN_S;
               size_d  = AWSIZE_S;
               beat_d  = '0;
               err_d   = 1'b0;
               state_d = W_DATA;
            end
         end
         R_FETCH: begin
            sram_cs   = 1'b1;
            sram_addr = addr_q[15:2];
            state_d   = R_SEND;
         end
         R_SEND: begin
            RVALID_S = 1'b1;
            RDATA_S  = sram_rdata;
            RID_S    = id_q;
            RLAST_S  = at_len;
            if (RREADY_S) begin
               if (at_len) begin
                  state_d = IDLE;
               end else begin
                  beat_d  = beat_inc;
                  addr_d  = addr_inc;
                  state_d = R_FETCH;
               end
            end
         end
         W_DATA: begin
            WREADY_S = 1'b1;
            if (WVALID_S) begin
               sram_cs    = 1'b1;
               sram_we    = WSTRB_S;
               sram_addr  = addr_q[15:2];
               sram_wdata = WDATA_S;
               beat_d     = beat_inc;
               addr_d     = addr_inc;
               if (WLAST_S != at_len) err_d = 1'b1;
               if (WLAST_S) state_d = W_RESP;
            end
         end
         W_RESP: begin
            BVALID_S = 1'b1;
            BID_S    = id_q;
            BRESP_S  = err_q ? 2'b10 : 2'b00;
            if (BREADY_S) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave with a behavioural SRAM model.
// Inputs change on the falling edge; outputs are sampled 1 unit later.
module tb_axi_sram_slave;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  ARID_S, AWID_S, RID_S, BID_S;
   logic [31:0] ARADDR_S, AWADDR_S, RDATA_S, WDATA_S;
   logic [3:0]  ARLEN_S, AWLEN_S, WSTRB_S, sram_we;
   logic [2:0]  ARSIZE_S, AWSIZE_S;
   logic [1:0]  ARBURST_S, AWBURST_S, RRESP_S, BRESP_S;
   logic        ARVALID_S, ARREADY_S, RLAST_S, RVALID_S, RREADY_S;
   logic        AWVALID_S, AWREADY_S, WLAST_S, WVALID_S, WREADY_S;
   logic        BVALID_S, BREADY_S, sram_cs;
   logic [13:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata = '0;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [0:16383];
   logic [13:0] wlog [$];

   always #5 clk = ~clk;

   axi_sram_slave dut (
      .clk(clk), .rst(rst),
      .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S),
      .ARSIZE_S(ARSIZE_S), .ARBURST_S(ARBURST_S),
      .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
      .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S),
      .RLAST_S(RLAST_S), .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
      .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S),
      .AWSIZE_S(AWSIZE_S), .AWBURST_S(AWBURST_S),
      .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
      .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S),
      .WVALID_S(WVALID_S), .WREADY_S(WREADY_S),
      .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S),
      .BREADY_S(BREADY_S),
      .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
   );

   // SRAM model: read data appears after a read strobe and holds.
   always @(posedge clk) begin
      if (sram_cs) begin
         if (sram_we == 4'b0000) begin
            sram_rdata <= mem[sram_addr];
         end else begin
            for (int k = 0; k < 4; k++)
               if (sram_we[k])
                  mem[sram_addr][8*k +: 8] <= sram_wdata[8*k +: 8];
            wlog.push_back(sram_addr);
         end
      end
   end

   task automatic aw_send(input logic [7:0] id, input logic [31:0] a,
                          input logic [3:0] l, input logic [2:0] s);
      AWID_S = id; AWADDR_S = a; AWLEN_S = l; AWSIZE_S = s;
      AWBURST_S = 2'b01; AWVALID_S = 1'b1;
      for (int n = 0; n < 40; n++) begin
         #1;
         if (AWREADY_S) begin
            @(negedge clk); AWVALID_S = 1'b0; return;
         end
         @(negedge clk);
      end
      AWVALID_S = 1'b0; checks++; errors++;
      $display("FAIL aw_handshake timeout got AWREADY 0 exp 1");
   endtask

   task automatic ar_send(input logic [7:0] id, input logic [31:0] a,
                          input logic [3:0] l, input logic [2:0] s);
      ARID_S = id; ARADDR_S = a; ARLEN_S = l; ARSIZE_S = s;
      ARBURST_S = 2'b01; ARVALID_S = 1'b1;
      for (int n = 0; n < 40; n++) begin
         #1;
         if (ARREADY_S) begin
            @(negedge clk); ARVALID_S = 1'b0; return;
         end
         @(negedge clk);
      end
      ARVALID_S = 1'b0; checks++; errors++;
      $display("FAIL ar_handshake timeout got ARREADY 0 exp 1");
   endtask

   task automatic w_send(input logic [31:0] d, input logic [3:0] st,
                         input logic last);
      WDATA_S = d; WSTRB_S = st; WLAST_S = last; WVALID_S = 1'b1;
      for (int n = 0; n < 40; n++) begin
         #1;
         if (WREADY_S) begin
            @(negedge clk); WVALID_S = 1'b0; WLAST_S = 1'b0; return;
         end
         @(negedge clk);
      end
      WVALID_S = 1'b0; WLAST_S = 1'b0; checks++; errors++;
      $display("FAIL w_handshake timeout got WREADY 0 exp 1");
   endtask

   task automatic r_recv(output logic [31:0] d, output logic l,
                         output logic [7:0] id, output logic [1:0] rs);
      RREADY_S = 1'b1;
      for (int n = 0; n < 40; n++) begin
         #1;
         if (RVALID_S) begin
            d = RDATA_S; l = RLAST_S; id = RID_S; rs = RRESP_S;
            @(negedge clk); RREADY_S = 1'b0; return;
         end
         @(negedge clk);
      end
      RREADY_S = 1'b0; d = 'x; l = 'x; id = 'x; rs = 'x;
      checks++; errors++;
      $display("FAIL r_handshake timeout got RVALID 0 exp 1");
   endtask

   task automatic b_recv(output logic [7:0] id, output logic [1:0] rs);
      BREADY_S = 1'b1;
      for (int n = 0; n < 40; n++) begin
         #1;
         if (BVALID_S) begin
            id = BID_S; rs = BRESP_S;
            @(negedge clk); BREADY_S = 1'b0; return;
         end
         @(negedge clk);
      end
      BREADY_S = 1'b0; id = 'x; rs = 'x; checks++; errors++;
      $display("FAIL b_handshake timeout got BVALID 0 exp 1");
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk); @(negedge clk); #1;
      checks++;
      if (ARREADY_S !== 1'b1) begin
         errors++; $display("FAIL reset_arready got %b exp 1", ARREADY_S);
      end
      checks++;
      if (AWREADY_S !== 1'b1) begin
         errors++; $display("FAIL reset_awready got %b exp 1", AWREADY_S);
      end
      checks++;
      if ({RVALID_S, BVALID_S, WREADY_S, sram_cs} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_idle_outs got %b exp 0000",
                  {RVALID_S, BVALID_S, WREADY_S, sram_cs});
      end
      ARVALID_S = 1'b1; #1;
      checks++;
      if (AWREADY_S !== 1'b0) begin
         errors++; $display("FAIL reset_awready_arv got %b exp 0", AWREADY_S);
      end
      ARVALID_S = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single();
      logic [31:0] d; logic l; logic [7:0] id; logic [1:0] rs;
      int base;
      base = wlog.size();
      aw_send(8'h5A, 32'h0000_0010, 4'd0, 3'd2);
      w_send(32'hDEADBEEF, 4'hF, 1'b1);
      b_recv(id, rs);
      checks++;
      if (wlog.size() !== base + 1 || wlog[base] !== 14'd4) begin
         errors++; $display("FAIL single_waddr got %0d exp 4", wlog[base]);
      end
      checks++;
      if (mem[4] !== 32'hDEADBEEF) begin
         errors++; $display("FAIL single_mem got %h exp deadbeef", mem[4]);
      end
      checks++;
      if (rs !== 2'b00 || id !== 8'h5A) begin
         errors++; $display("FAIL single_b got %h/%b exp 5a/00", id, rs);
      end
      ar_send(8'h3C, 32'h0000_0010, 4'd0, 3'd2);
      r_recv(d, l, id, rs);
      checks++;
      if (d !== 32'hDEADBEEF) begin
         errors++; $display("FAIL single_rdata got %h exp deadbeef", d);
      end
      checks++;
      if (l !== 1'b1 || id !== 8'h3C || rs !== 2'b00) begin
         errors++;
         $display("FAIL single_r got last %b id %h resp %b exp 1 3c 00",
                  l, id, rs);
      end
   endtask

   task automatic test_burst();
      logic [7:0] id; logic [1:0] rs; logic [31:0] d0;
      int base; int n;
      base = wlog.size();
      aw_send(8'h11, 32'h0000_0100, 4'd3, 3'd2);
      for (int i = 0; i < 4; i++) w_send(32'(i + 1), 4'hF, i == 3);
      b_recv(id, rs);
      checks++;
      if (wlog.size() !== base + 4) begin
         errors++;
         $display("FAIL burst_wcount got %0d exp 4", wlog.size() - base);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (wlog[base + i] !== 14'(14'h40 + i)) begin
            errors++;
            $display("FAIL burst_waddr%0d got %h exp %h",
                     i, wlog[base + i], 14'h40 + i);
         end
      end
      checks++;
      if (rs !== 2'b00) begin
         errors++; $display("FAIL burst_bresp got %b exp 00", rs);
      end
      ar_send(8'h22, 32'h0000_0100, 4'd3, 3'd2);
      for (int i = 0; i < 4; i++) begin
         RREADY_S = 1'b0; n = 0; #1;
         while (!RVALID_S && n < 20) begin
            @(negedge clk); #1; n++;
         end
         d0 = RDATA_S;
         checks++;
         if (RVALID_S !== 1'b1 || d0 !== 32'(i + 1)) begin
            errors++;
            $display("FAIL burst_rdata%0d got %h exp %h", i, d0, i + 1);
         end
         checks++;
         if (RLAST_S !== (i == 3)) begin
            errors++;
            $display("FAIL burst_rlast%0d got %b exp %b", i, RLAST_S, i == 3);
         end
         @(negedge clk); #1;
         checks++;
         if (RVALID_S !== 1'b1 || RDATA_S !== d0) begin
            errors++;
            $display("FAIL burst_stall%0d got %b/%h exp 1/%h",
                     i, RVALID_S, RDATA_S, d0);
         end
         RREADY_S = 1'b1;
         @(negedge clk);
         RREADY_S = 1'b0;
      end
      #1;
      checks++;
      if (RVALID_S !== 1'b0 || ARREADY_S !== 1'b1) begin
         errors++;
         $display("FAIL burst_end got rvalid %b arready %b exp 0 1",
                  RVALID_S, ARREADY_S);
      end
      @(negedge clk);
   endtask

   task automatic test_strobe();
      logic [31:0] d; logic l; logic [7:0] id; logic [1:0] rs;
      mem[8] <= 32'h11223344;
      @(negedge clk);
      aw_send(8'h01, 32'h0000_0020, 4'd0, 3'd2);
      w_send(32'hAABBCCDD, 4'b0101, 1'b1);
      b_recv(id, rs);
      ar_send(8'h02, 32'h0000_0020, 4'd0, 3'd2);
      r_recv(d, l, id, rs);
      checks++;
      if (d !== 32'h11BB33DD) begin
         errors++; $display("FAIL strobe_rdata got %h exp 11bb33dd", d);
      end
   endtask

   task automatic test_simultaneous();
      logic [31:0] d; logic l; logic [7:0] id; logic [1:0] rs;
      int base;
      base = wlog.size();
      ARID_S = 8'h07; ARADDR_S = 32'h10; ARLEN_S = 4'd0; ARSIZE_S = 3'd2;
      AWID_S = 8'h08; AWADDR_S = 32'h30; AWLEN_S = 4'd0; AWSIZE_S = 3'd2;
      ARVALID_S = 1'b1; AWVALID_S = 1'b1; #1;
      checks++;
      if (ARREADY_S !== 1'b1 || AWREADY_S !== 1'b0) begin
         errors++;
         $display("FAIL simul_ready got ar %b aw %b exp 1 0",
                  ARREADY_S, AWREADY_S);
      end
      @(negedge clk);
      ARVALID_S = 1'b0;
      r_recv(d, l, id, rs);
      checks++;
      if (d !== 32'hDEADBEEF || l !== 1'b1 || id !== 8'h07) begin
         errors++;
         $display("FAIL simul_read got %h %b %h exp deadbeef 1 07", d, l, id);
      end
      checks++;
      if (wlog.size() !== base) begin
         errors++;
         $display("FAIL simul_order got %0d writes exp 0", wlog.size() - base);
      end
      aw_send(8'h08, 32'h30, 4'd0, 3'd2);
      w_send(32'hCAFEF00D, 4'hF, 1'b1);
      b_recv(id, rs);
      checks++;
      if (id !== 8'h08 || rs !== 2'b00 || mem[12] !== 32'hCAFEF00D) begin
         errors++;
         $display("FAIL simul_write got %h %b %h exp 08 00 cafef00d",
                  id, rs, mem[12]);
      end
   endtask

   task automatic test_wlast_err();
      logic [7:0] id; logic [1:0] rs;
      int base;
      base = wlog.size();
      aw_send(8'h03, 32'h0000_0200, 4'd3, 3'd2);
      w_send(32'hA0, 4'hF, 1'b0);
      w_send(32'hA1, 4'hF, 1'b1);
      b_recv(id, rs);
      checks++;
      if (wlog.size() !== base + 2 || wlog[base] !== 14'h80 ||
          wlog[base + 1] !== 14'h81) begin
         errors++;
         $display("FAIL early_wlast_writes got %0d exp 2", wlog.size() - base);
      end
      checks++;
      if (rs !== 2'b10 || id !== 8'h03) begin
         errors++; $display("FAIL early_wlast_b got %h/%b exp 03/10", id, rs);
      end
      aw_send(8'h04, 32'h0000_0240, 4'd0, 3'd2);
      w_send(32'hB0, 4'hF, 1'b0);
      w_send(32'hB1, 4'hF, 1'b1);
      b_recv(id, rs);
      checks++;
      if (rs !== 2'b10) begin
         errors++; $display("FAIL late_wlast_bresp got %b exp 10", rs);
      end
      checks++;
      if (mem[16'h91] !== 32'hB1) begin
         errors++; $display("FAIL late_wlast_mem got %h exp b1", mem[16'h91]);
      end
   endtask

   task automatic test_wrap();
      logic [7:0] id; logic [1:0] rs;
      int base;
      base = wlog.size();
      aw_send(8'h05, 32'h0000_FFFC, 4'd1, 3'd2);
      w_send(32'hC0, 4'hF, 1'b0);
      w_send(32'hC1, 4'hF, 1'b1);
      b_recv(id, rs);
      checks++;
      if (wlog[base] !== 14'h3FFF || wlog[base + 1] !== 14'h0000) begin
         errors++;
         $display("FAIL wrap_addr got %h %h exp 3fff 0000",
                  wlog[base], wlog[base + 1]);
      end
      checks++;
      if (rs !== 2'b00) begin
         errors++; $display("FAIL wrap_bresp got %b exp 00", rs);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d; logic l; logic [7:0] id; logic [1:0] rs;
      int n; logic seen;
      for (int i = 0; i < 8; i++) mem[8'hC0 + i] <= 32'h500 + i;
      mem[4] <= 32'hDEADBEEF;
      @(negedge clk);
      ar_send(8'h09, 32'h0000_0300, 4'd7, 3'd2);
      r_recv(d, l, id, rs);
      checks++;
      if (d !== 32'h500 || l !== 1'b0) begin
         errors++; $display("FAIL rmid_beat1 got %h/%b exp 500/0", d, l);
      end
      RREADY_S = 1'b0; n = 0; #1;
      while (!RVALID_S && n < 20) begin
         @(negedge clk); #1; n++;
      end
      checks++;
      if (RVALID_S !== 1'b1 || RDATA_S !== 32'h501) begin
         errors++;
         $display("FAIL rmid_beat2 got %b/%h exp 1/501", RVALID_S, RDATA_S);
      end
      rst = 1'b1;
      @(negedge clk); #1;
      checks++;
      if (RVALID_S !== 1'b0 || ARREADY_S !== 1'b1) begin
         errors++;
         $display("FAIL rmid_after_rst got rvalid %b arready %b exp 0 1",
                  RVALID_S, ARREADY_S);
      end
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         if (RVALID_S) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++; $display("FAIL rmid_dropped got rvalid 1 exp 0");
      end
      @(negedge clk);
      ar_send(8'h0A, 32'h0000_0010, 4'd0, 3'd2);
      r_recv(d, l, id, rs);
      checks++;
      if (d !== 32'hDEADBEEF || l !== 1'b1 || id !== 8'h0A) begin
         errors++;
         $display("FAIL rmid_new_ar got %h %b %h exp deadbeef 1 0a", d, l, id);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      ARID_S = '0; ARADDR_S = '0; ARLEN_S = '0; ARSIZE_S = '0;
      ARBURST_S = '0; ARVALID_S = 1'b0; RREADY_S = 1'b0;
      AWID_S = '0; AWADDR_S = '0; AWLEN_S = '0; AWSIZE_S = '0;
      AWBURST_S = '0; AWVALID_S = 1'b0;
      WDATA_S = '0; WSTRB_S = '0; WLAST_S = 1'b0; WVALID_S = 1'b0;
      BREADY_S = 1'b0;
      @(negedge clk);
      test_reset();
      test_single();
      test_burst();
      test_strobe();
      test_simultaneous();
      test_wlast_err();
      test_wrap();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
